// File: rtl/regfile_sb.sv
// Integer register file for the pipelined RISC-V core: NRD combinational read
// ports, one write port, x0 hardwired to zero, post-reset clear FSM, busy scoreboard.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NREG - 1);
  localparam logic          BYPASS_EN = (BYPASS != 0);

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            init_done_q, init_done_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] mem_q [NREG];

  logic            run;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  assign run       = (state_q == ST_RUN);
  assign init_done = init_done_q;

  // Clear sequencer next state: walk x1..x[NREG-1], then settle in RUN.
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + ADDR_ONE;
        if (clr_idx_q == ADDR_LAST) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          state_d     = ST_CLEAR;
          init_done_d = 1'b0;
        end
      end
      ST_RUN: begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
      default: begin
        state_d     = ST_CLEAR;
        clr_idx_d   = ADDR_ONE;
        init_done_d = 1'b0;
      end
    endcase
  end

  // Storage write mux: the clear sequencer owns the port until RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx_q;
      mem_wdata = {XLEN{1'b0}};
    end else begin
      mem_we    = we && (waddr != ADDR_ZERO);
      mem_waddr = waddr;
      mem_wdata = wdata;
    end
  end

  // Scoreboard next state: a new issue wins over flush, flush over writeback.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      for (int r = 1; r < NREG; r++) begin
        if (iss_valid && (iss_rd == AW'(r))) begin
          busy_d[r] = 1'b1;
        end else if (flush) begin
          busy_d[r] = 1'b0;
        end else if (we && (waddr == AW'(r))) begin
          busy_d[r] = 1'b0;
        end else begin
          busy_d[r] = busy_q[r];
        end
      end
    end else begin
      busy_d = {NREG{1'b0}};
    end
    busy_d[0] = 1'b0;
  end

  // Control state with asynchronous reset back into the clear sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= ADDR_ONE;
      init_done_q <= 1'b0;
      busy_q      <= {NREG{1'b0}};
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
    end
  end

  // Register storage carries no reset; the clear sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            fwd;
    logic [XLEN-1:0] rd_val;
    logic            rd_busy;

    assign ra  = raddr[i*AW +: AW];
    assign fwd = BYPASS_EN && we && (waddr == ra) && (ra != ADDR_ZERO);

    // Read port: a forwarded result is reported with its data and as ready.
    always_comb begin
      rd_val  = {XLEN{1'b0}};
      rd_busy = 1'b0;
      if (!run || (ra == ADDR_ZERO)) begin
        rd_val  = {XLEN{1'b0}};
        rd_busy = 1'b0;
      end else if (fwd) begin
        rd_val  = wdata;
        rd_busy = 1'b0;
      end else begin
        rd_val  = mem_q[ra];
        rd_busy = busy_q[ra];
      end
    end

    assign rdata[i*XLEN +: XLEN] = rd_val;
    assign rbusy[i]              = rd_busy;
  end

  regfile_sb_chk #(
    .NREG (NREG),
    .NRD  (NRD)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .init_done (init_done_q),
    .busy      (busy_q),
    .rbusy     (rbusy)
  );

endmodule

// Structural invariants of the register file, kept apart from the datapath.
module regfile_sb_chk #(
  parameter int NREG = 32,
  parameter int NRD  = 2
) (
  input logic            clk,
  input logic            rst,
  input logic            run,
  input logic            init_done,
  input logic [NREG-1:0] busy,
  input logic [NRD-1:0]  rbusy
);

  a_x0_never_busy: assert property (@(posedge clk) disable iff (rst) !busy[0])
    else $error("regfile_sb_chk: busy[0] set");

  a_done_tracks_run: assert property (@(posedge clk) disable iff (rst) init_done == run)
    else $error("regfile_sb_chk: init_done disagrees with state");

  a_clear_not_busy: assert property (@(posedge clk) disable iff (rst) run || (rbusy == {NRD{1'b0}}))
    else $error("regfile_sb_chk: rbusy during clear");

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one forwarding instance and one without bypass.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  raddr;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        flush;

  logic        init_done, init_done_nb;
  logic [63:0] rdata, rdata_nb;
  logic [1:0]  rbusy, rbusy_nb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREG(32), .AW(5), .NRD(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .raddr(raddr), .rdata(rdata),
    .rbusy(rbusy), .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .flush(flush)
  );

  regfile_sb #(.XLEN(32), .NREG(32), .AW(5), .NRD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .init_done(init_done_nb), .raddr(raddr), .rdata(rdata_nb),
    .rbusy(rbusy_nb), .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .flush(flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we        = 1'b0;
    waddr     = 5'd0;
    wdata     = 32'h0000_0000;
    iss_valid = 1'b0;
    iss_rd    = 5'd0;
    flush     = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    raddr = {a1, a0};
  endtask

  // Counts clocks from reset release until init_done, bounded at 40.
  task automatic wait_init(input string tag);
    int cnt;
    cnt = 0;
    while (!init_done && cnt < 40) begin
      step();
      cnt++;
    end
    check(tag, 32'(cnt), 32'd31);
    check({tag, "_nb"}, {31'd0, init_done_nb}, 32'd1);
  endtask

  initial begin
    idle();
    raddr = 10'd0;
    rst   = 1'b1;
    repeat (3) step();
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_rbusy", {30'd0, rbusy}, 32'd0);

    // Release reset; inputs driven during clear must be ignored.
    rst       = 1'b0;
    we        = 1'b1;
    waddr     = 5'd5;
    wdata     = 32'hAAAA_AAAA;
    iss_valid = 1'b1;
    iss_rd    = 5'd5;
    set_rd(5'd5, 5'd5);
    #1;
    check("clear_rdata", rdata[31:0], 32'h0000_0000);
    check("clear_rbusy", {30'd0, rbusy}, 32'd0);
    wait_init("clear_len1");
    idle();
    #1;
    check("clear_ign_wr", rdata[31:0], 32'h0000_0000);
    check("clear_ign_iss", {30'd0, rbusy}, 32'd0);

    // Fill every register with garbage, then prove the clear wipes it.
    for (int a = 1; a < 32; a++) begin
      we    = 1'b1;
      waddr = 5'(a);
      wdata = 32'hA500_0000 | 32'(a);
      step();
    end
    idle();
    set_rd(5'd17, 5'd31);
    #1;
    check("fill_x17", rdata[31:0], 32'hA500_0011);
    check("fill_x31", rdata[63:32], 32'hA500_001F);
    check("fill_nb_x17", rdata_nb[31:0], 32'hA500_0011);

    iss_valid = 1'b1;
    iss_rd    = 5'd3;
    step();
    idle();
    set_rd(5'd3, 5'd3);
    #1;
    check("busy_x3", {30'd0, rbusy}, 32'd3);

    // Reset in RUN takes effect immediately.
    #2 rst = 1'b1;
    #1;
    check("run_rst_done", {31'd0, init_done}, 32'd0);
    check("run_rst_busy", {30'd0, rbusy}, 32'd0);
    step();
    rst = 1'b0;
    wait_init("clear_len2");
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(a));
      #1;
      check("cleared", rdata[31:0] | rdata[63:32] | rdata_nb[31:0], 32'h0000_0000);
    end
    check("cleared_busy", {30'd0, rbusy}, 32'd0);

    // Same-cycle forwarding versus none.
    we    = 1'b1;
    waddr = 5'd5;
    wdata = 32'hDEAD_BEEF;
    set_rd(5'd5, 5'd0);
    #1;
    check("byp_fwd", rdata[31:0], 32'hDEAD_BEEF);
    check("nobyp_old", rdata_nb[31:0], 32'h0000_0000);
    step();
    idle();
    #1;
    check("byp_next", rdata[31:0], 32'hDEAD_BEEF);
    check("nobyp_next", rdata_nb[31:0], 32'hDEAD_BEEF);

    // x0 is immune to writes and issues.
    we        = 1'b1;
    waddr     = 5'd0;
    wdata     = 32'h0000_1234;
    iss_valid = 1'b1;
    iss_rd    = 5'd0;
    set_rd(5'd0, 5'd0);
    #1;
    check("x0_fwd", rdata[31:0], 32'h0000_0000);
    check("x0_busy_now", {30'd0, rbusy}, 32'd0);
    step();
    idle();
    #1;
    check("x0_rd", rdata[31:0] | rdata_nb[31:0], 32'h0000_0000);
    check("x0_busy", {30'd0, rbusy}, 32'd0);

    // Issue / writeback on x7.
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    set_rd(5'd0, 5'd7);
    #1;
    check("x7_not_yet", {31'd0, rbusy[1]}, 32'd0);
    step();
    idle();
    #1;
    check("x7_busy", {31'd0, rbusy[1]}, 32'd1);
    check("x7_busy_nb", {31'd0, rbusy_nb[1]}, 32'd1);
    we    = 1'b1;
    waddr = 5'd7;
    wdata = 32'h0000_0077;
    #1;
    check("x7_wb_ready", {31'd0, rbusy[1]}, 32'd0);
    check("x7_wb_nb", {31'd0, rbusy_nb[1]}, 32'd1);
    check("x7_wb_data", rdata[63:32], 32'h0000_0077);
    step();
    idle();
    #1;
    check("x7_cleared", {31'd0, rbusy[1]}, 32'd0);
    check("x7_cleared_nb", {31'd0, rbusy_nb[1]}, 32'd0);
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    step();
    we    = 1'b1;
    waddr = 5'd7;
    wdata = 32'h0000_0777;
    step();
    idle();
    #1;
    check("x7_set_wins", {31'd0, rbusy[1]}, 32'd1);
    check("x7_set_data", rdata[63:32], 32'h0000_0777);
    we    = 1'b1;
    waddr = 5'd7;
    step();
    idle();

    // Flush clears everything pending, but a same-cycle issue survives.
    iss_valid = 1'b1;
    iss_rd    = 5'd3;
    step();
    iss_rd = 5'd9;
    step();
    idle();
    set_rd(5'd3, 5'd9);
    #1;
    check("busy_3_9", {30'd0, rbusy}, 32'd3);
    flush = 1'b1;
    step();
    idle();
    #1;
    check("flush_all", {30'd0, rbusy}, 32'd0);
    iss_valid = 1'b1;
    iss_rd    = 5'd3;
    step();
    iss_rd = 5'd9;
    step();
    flush = 1'b1;
    step();
    idle();
    #1;
    check("flush_iss9", {30'd0, rbusy}, 32'd2);
    set_rd(5'd9, 5'd9);
    #1;
    check("same_busy", {30'd0, rbusy}, 32'd3);

    // Non-busy write is legal; identical addresses read identically.
    we    = 1'b1;
    waddr = 5'd10;
    wdata = 32'h1234_5678;
    step();
    idle();
    set_rd(5'd10, 5'd10);
    #1;
    check("x10_p0", rdata[31:0], 32'h1234_5678);
    check("x10_p1", rdata[63:32], 32'h1234_5678);
    check("x10_busy", {30'd0, rbusy}, 32'd0);

    // Reset mid-clear at clr_idx 10 restarts the full sequence.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (9) step();
    #2 rst = 1'b1;
    #1;
    check("midclr_done", {31'd0, init_done}, 32'd0);
    step();
    rst = 1'b0;
    wait_init("clear_len3");
    set_rd(5'd10, 5'd9);
    #1;
    check("midclr_x10", rdata[31:0] | rdata[63:32], 32'h0000_0000);
    check("midclr_busy", {30'd0, rbusy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
